// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator with PLL lock qualification.
// Optional macro CLKEN_TOGGLE_EN builds a per-channel 50% toggle output on ce_tgl.
module clk_en_gen #(
  parameter int CH_NUM      = 4,
  parameter int ACC_W       = 24,
  parameter int INC_DEFAULT = 0,
  parameter int LOCK_CYC    = 1024,
  localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock_in,
  input  logic              restart,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ACC_W-1:0]  wr_data,
  output logic              ready,
  output logic [CH_NUM-1:0] ce,
  output logic [CH_NUM-1:0] ce_tgl
);

  localparam int LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);
  localparam logic [ACC_W-1:0]  INC_INIT  = ACC_W'(INC_DEFAULT);

  logic [LOCK_W-1:0] lock_cnt_reg;
  logic              ready_reg;
  logic              acc_clr;

  // Counter freezes once ready; any low lock_in sample restarts qualification.
  always_ff @(posedge clk) begin
    if (rst || !lock_in) begin
      lock_cnt_reg <= '0;
      ready_reg    <= 1'b0;
    end else if (!ready_reg) begin
      if (lock_cnt_reg == LOCK_LAST) begin
        ready_reg <= 1'b1;
      end else begin
        lock_cnt_reg <= lock_cnt_reg + LOCK_W'(1);
      end
    end
  end

  assign ready   = ready_reg;
  // restart only matters once the generators are running.
  assign acc_clr = rst || !lock_in || (ready_reg && restart);

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

      logic [ACC_W-1:0] inc_reg;
      logic [ACC_W-1:0] acc_reg;
      logic             ce_reg;
      logic [ACC_W:0]   sum_next;

      assign sum_next = {1'b0, acc_reg} + {1'b0, inc_reg};

      // Out-of-range channel indices never match any CH_IDX, so they are ignored.
      always_ff @(posedge clk) begin
        if (rst) begin
          inc_reg <= INC_INIT;
        end else if (wr_en && (wr_ch == CH_IDX)) begin
          inc_reg <= wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (acc_clr) begin
          acc_reg <= '0;
          ce_reg  <= 1'b0;
        end else if (ready_reg) begin
          acc_reg <= sum_next[ACC_W-1:0];
          ce_reg  <= sum_next[ACC_W];
        end else begin
          ce_reg  <= 1'b0;
        end
      end

      assign ce[gi] = ce_reg;

`ifdef CLKEN_TOGGLE_EN
      logic tgl_reg;

      always_ff @(posedge clk) begin
        if (acc_clr) begin
          tgl_reg <= 1'b0;
        end else if (ready_reg && sum_next[ACC_W]) begin
          tgl_reg <= ~tgl_reg;
        end
      end

      assign ce_tgl[gi] = tgl_reg;
`else
      assign ce_tgl[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: phase-sum reference model compared every cycle,
// plus directed phases with hand-computed strobe patterns.
module tb_clk_en_gen;

  // Three channels so the 2-bit write index has an unused code (3) to exercise.
  localparam int CH_NUM      = 3;
  localparam int ACC_W       = 8;
  localparam int INC_DEFAULT = 0;
  localparam int LOCK_CYC    = 4;
  localparam int CH_W        = 2;
  localparam int MOD         = 1 << ACC_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              lock_in;
  logic              restart;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [ACC_W-1:0]  wr_data;
  logic              ready;
  logic [CH_NUM-1:0] ce;
  logic [CH_NUM-1:0] ce_tgl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_en_gen #(
    .CH_NUM      (CH_NUM),
    .ACC_W       (ACC_W),
    .INC_DEFAULT (INC_DEFAULT),
    .LOCK_CYC    (LOCK_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .lock_in (lock_in),
    .restart (restart),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .ready   (ready),
    .ce      (ce),
    .ce_tgl  (ce_tgl)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: ready after LOCK_CYC consecutive lock-high samples; each channel
  // keeps an integer phase, a strobe is emitted whenever the phase passes 2^ACC_W.
  int                run;
  bit                m_ready;
  bit                m_valid = 1'b0;
  int                ph    [CH_NUM];
  int                m_inc [CH_NUM];
  logic [CH_NUM-1:0] m_ce;
  logic [CH_NUM-1:0] m_tgl;

  initial forever begin
    @(posedge clk);
    m_valid = 1'b1;
    if (rst) begin
      run = 0;
      m_ready = 1'b0;
      m_ce = '0;
      m_tgl = '0;
      for (int i = 0; i < CH_NUM; i++) begin
        ph[i] = 0;
        m_inc[i] = INC_DEFAULT;
      end
    end else begin
      if (!lock_in) begin
        run = 0;
        m_ready = 1'b0;
        m_ce = '0;
        m_tgl = '0;
        for (int i = 0; i < CH_NUM; i++) ph[i] = 0;
      end else if (!m_ready) begin
        run++;
        m_ready = (run >= LOCK_CYC);
        m_ce = '0;
      end else if (restart) begin
        m_ce = '0;
        m_tgl = '0;
        for (int i = 0; i < CH_NUM; i++) ph[i] = 0;
      end else begin
        for (int i = 0; i < CH_NUM; i++) begin
          ph[i] = ph[i] + m_inc[i];
          m_ce[i] = (ph[i] >= MOD);
          ph[i] = ph[i] % MOD;
`ifdef CLKEN_TOGGLE_EN
          m_tgl[i] = m_tgl[i] ^ m_ce[i];
`endif
        end
      end
      // The write lands after this cycle's add, which therefore used the old increment.
      if (wr_en && (int'(wr_ch) < CH_NUM)) m_inc[wr_ch] = int'(wr_data);
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("cmp_ready", 32'(ready), 32'(m_ready));
      check("cmp_ce", 32'(ce), 32'(m_ce));
      check("cmp_ce_tgl", 32'(ce_tgl), 32'(m_tgl));
    end
  end

  logic [15:0]       pat0, pat1, patt;
  logic [7:0]        p8;
  logic [CH_NUM-1:0] rs [4];
  int                n0, n1, n2;

  initial begin
    rst = 1'b1; lock_in = 1'b0; restart = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    step();
    step();
    $display("reset: ready=%0b ce=%b ce_tgl=%b", ready, ce, ce_tgl);
    check("reset_ready", 32'(ready), 0);
    check("reset_ce", 32'(ce), 0);
    check("reset_ce_tgl", 32'(ce_tgl), 0);

    // Lock qualify; inc[0]=0x40 at edge 1 and inc[1]=0x60 at edge 2.
    rst = 1'b0; lock_in = 1'b1;
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'h40;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin
        wr_ch = 2'd1; wr_data = 8'h60;
      end else begin
        wr_en = 1'b0;
      end
      $display("lock edge %0d: ready=%0b ce=%b", k, ready, ce);
      check("lock_ready", 32'(ready), 32'(k == 4));
      check("lock_ce", 32'(ce), 0);
    end

    // Rates A and B over 16 cycles after ready.
    pat0 = '0; pat1 = '0; patt = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      pat0[k] = ce[0];
      pat1[k] = ce[1];
      patt[k] = ce_tgl[0];
    end
    $display("rates: ce0=%h ce1=%h tgl0=%h", pat0, pat1, patt);
    check("rate_a_pattern", 32'(pat0), 32'h8888);
    check("rate_b_pattern", 32'(pat1), 32'hA4A4);
`ifdef CLKEN_TOGGLE_EN
    check("tgl_pattern", 32'(patt), 32'h7878);
`else
    check("tgl_zero", 32'(patt), 0);
`endif

    // inc[1]=0 silences channel 1; channel 0 keeps one strobe per 4 cycles.
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'h00;
    step();
    wr_en = 1'b0;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      n0 += int'(ce[0]);
      n1 += int'(ce[1]);
    end
    $display("inc1=0 window: ce0 pulses=%0d ce1 pulses=%0d", n0, n1);
    check("inc_zero_pulses", 32'(n1), 0);
    check("rate_a_count", 32'(n0), 250);

    // One-cycle lock loss.
    lock_in = 1'b0;
    step();
    $display("lock loss: ready=%0b ce=%b", ready, ce);
    check("loss_ready", 32'(ready), 0);
    check("loss_ce", 32'(ce), 0);
    lock_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("relock_ready", 32'(ready), 32'(k == 4));
      check("relock_ce", 32'(ce), 0);
    end
    p8 = '0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      p8[k] = ce[0];
      n1 += int'(ce[1]);
    end
    $display("relock: ce0=%h ce1 pulses=%0d", p8, n1);
    check("relock_pattern", 32'(p8), 32'h88);
    check("relock_ce1", 32'(n1), 0);

    // Out-of-range write must not touch any increment.
    wr_en = 1'b1; wr_ch = 2'd3; wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    n0 = 0; n1 = 0; n2 = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      n0 += int'(ce[0]);
      n1 += int'(ce[1]);
      n2 += int'(ce[2]);
    end
    $display("bad write: pulses ce0=%0d ce1=%0d ce2=%0d", n0, n1, n2);
    check("badwr_ce0", 32'(n0), 2);
    check("badwr_ce1", 32'(n1), 0);
    check("badwr_ce2", 32'(n2), 0);

    // Restart aligns ch0/ch1 (both 0x40); a write to ch2 in the same cycle also lands.
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'h40;
    step();
    wr_ch = 2'd2; wr_data = 8'h80; restart = 1'b1;
    step();
    wr_en = 1'b0; restart = 1'b0;
    check("restart_ce", 32'(ce), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      rs[k] = ce;
    end
    $display("restart: ce=%b %b %b %b", rs[0], rs[1], rs[2], rs[3]);
    check("restart_s1", 32'(rs[0]), 32'b000);
    check("restart_s2", 32'(rs[1]), 32'b100);
    check("restart_s3", 32'(rs[2]), 32'b000);
    check("restart_s4", 32'(rs[3]), 32'b111);

    // Reset mid-run restores default (zero) increments.
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("mid reset: ready=%0b ce=%b", ready, ce);
    check("midrst_ready", 32'(ready), 0);
    check("midrst_ce", 32'(ce), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("midrst_relock", 32'(ready), 32'(k == 4));
    end
    n0 = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      n0 += $countones(ce);
    end
    $display("after reset: total pulses=%0d", n0);
    check("midrst_no_pulses", 32'(n0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
